// File: rtl/uart_tx.sv
// 8-bit UART transmitter: FIFO_DEPTH-entry write FIFO feeding a start/data/parity/stop
// framer. Frame settings are captured when a byte leaves the FIFO.
module uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] divider_i,
  input  logic        tx_en_i,
  input  logic        parity_en_i,
  input  logic        parity_odd_i,
  input  logic        stop2_i,
  input  logic [7:0]  tx_d_i,
  input  logic        tx_d_valid_i,
  input  logic        ovf_clr_i,
  input  logic [1:0]  txirqmask_i,
  output logic        tx_o,
  output logic [31:0] tx_status_o,
  output logic        tx_irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  state_e        state_q;
  logic [7:0]    shift_q;
  logic [31:0]   div_q;
  logic [31:0]   cnt_q;
  logic [2:0]    bit_idx_q;
  logic          par_en_q;
  logic          par_bit_q;
  logic          stop2_q;
  logic          stop_idx_q;
  logic          tx_q;
  logic          irq_q;

  logic          fifo_empty, fifo_full, busy, pop, push;
  logic [7:0]    head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign busy       = (state_q != IDLE);
  assign pop        = (state_q == IDLE) && !fifo_empty && tx_en_i && (divider_i != 32'd0);
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign push       = tx_d_valid_i && (!fifo_full || pop);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (ovf_clr_i) ovf_d = 1'b0;
    if (tx_d_valid_i && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_d_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      ovf_q   <= ovf_d;
      irq_q   <= (txirqmask_i[0] & fifo_empty & ~busy) | (txirqmask_i[1] & ovf_q);
    end
  end

  // Each bit holds for div_q cycles: cnt_q is loaded with div_q-1 and the bit ends at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            shift_q    <= head;
            div_q      <= divider_i;
            cnt_q      <= divider_i - 32'd1;
            par_en_q   <= parity_en_i;
            par_bit_q  <= (^head) ^ parity_odd_i;
            stop2_q    <= stop2_i;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
          end
        end
        START: begin
          if (cnt_q == 32'd0) begin
            state_q   <= DATA;
            cnt_q     <= div_q - 32'd1;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        DATA: begin
          if (cnt_q == 32'd0) begin
            cnt_q <= div_q - 32'd1;
            if (bit_idx_q == 3'd7) begin
              if (par_en_q) begin
                state_q <= PARITY;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        PARITY: begin
          if (cnt_q == 32'd0) begin
            state_q <= STOP;
            cnt_q   <= div_q - 32'd1;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        STOP: begin
          if (cnt_q == 32'd0) begin
            if (stop2_q && !stop_idx_q) begin
              stop_idx_q <= 1'b1;
              cnt_q      <= div_q - 32'd1;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx_o        = tx_q;
  assign tx_irq_o    = irq_q;
  assign tx_status_o = {24'd0, 4'(count_q), ovf_q, fifo_full, fifo_empty, busy};

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shapes, latency, FIFO full/overflow, reset and irq.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] divider = 32'd0;
  logic        txEn = 1'b0;
  logic        parityEn = 1'b0;
  logic        parityOdd = 1'b0;
  logic        stop2 = 1'b0;
  logic [7:0]  txData = 8'd0;
  logic        txValid = 1'b0;
  logic        ovfClr = 1'b0;
  logic [1:0]  irqMask = 2'b00;
  logic        txLine;
  logic [31:0] txStatus;
  logic        txIrq;

  int nCompared = 0;
  int nMismatch = 0;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .divider_i    (divider),
    .tx_en_i      (txEn),
    .parity_en_i  (parityEn),
    .parity_odd_i (parityOdd),
    .stop2_i      (stop2),
    .tx_d_i       (txData),
    .tx_d_valid_i (txValid),
    .ovf_clr_i    (ovfClr),
    .txirqmask_i  (irqMask),
    .tx_o         (txLine),
    .tx_status_o  (txStatus),
    .tx_irq_o     (txIrq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nCompared++;
    assert (observed === expected) else begin
      nMismatch++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One-cycle write strobe; returns on the following falling edge.
  task automatic applyStimulus(input logic [7:0] b);
    txData  = b;
    txValid = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // Waits up to waitMax falling edges for the start bit, then checks line and busy
  // every cycle of the frame; skip = start-bit cycles already elapsed.
  task automatic expectFrame(input logic [7:0] b, input int div, input bit parEn, input bit parBit,
                             input bit twoStop, input int skip, input int waitMax);
    int waited = 0;
    bit bits[$];
    while (txLine !== 1'b0 && waited < waitMax) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("frameStart", 32'(txLine), 32'd0);
    if (txLine !== 1'b0) return;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (parEn) bits.push_back(parBit);
    bits.push_back(1'b1);
    if (twoStop) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = (k == 0) ? skip : 0; c < div; c++) begin
        checkOutput($sformatf("frame%02h_bit%0d", b, k), 32'({txLine, txStatus[0]}), 32'({bits[k], 1'b1}));
        @(negedge clk);
      end
    end
    checkOutput("frameEnd", 32'(txStatus[0]), 32'd0);
  endtask

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstTx", 32'(txLine), 32'd1);
    checkOutput("rstStatus", txStatus, 32'h2);
    checkOutput("rstIrq", 32'(txIrq), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstStatus", txStatus, 32'h2);

    // 8N1, divider 4, byte 0x55, with strobe-to-start latency
    $display("[TB] 8N1 divider 4");
    divider = 32'd4;
    txEn = 1'b1;
    applyStimulus(8'h55);
    checkOutput("latencyIdle", 32'(txLine), 32'd1);
    expectFrame(8'h55, 4, 1'b0, 1'b0, 1'b0, 0, 1);
    checkOutput("after55Status", txStatus, 32'h2);

    // Even then odd parity, divider 2, byte 0x07
    $display("[TB] parity divider 2");
    divider = 32'd2;
    parityEn = 1'b1;
    parityOdd = 1'b0;
    applyStimulus(8'h07);
    expectFrame(8'h07, 2, 1'b1, 1'b1, 1'b0, 0, 1);
    parityOdd = 1'b1;
    applyStimulus(8'h07);
    expectFrame(8'h07, 2, 1'b1, 1'b0, 1'b0, 0, 1);
    parityEn = 1'b0;
    parityOdd = 1'b0;

    // Two stop bits, back-to-back 0xA0 / 0x0F with exactly one idle cycle between
    $display("[TB] two stop bits back-to-back");
    divider = 32'd3;
    stop2 = 1'b1;
    txData = 8'hA0;
    txValid = 1'b1;
    @(negedge clk);
    txData = 8'h0F;
    @(negedge clk);
    txValid = 1'b0;
    expectFrame(8'hA0, 3, 1'b0, 1'b0, 1'b1, 0, 0);
    expectFrame(8'h0F, 3, 1'b0, 1'b0, 1'b1, 0, 1);
    stop2 = 1'b0;

    // Six consecutive writes at divider 100: one popped, four buffered, one dropped
    $display("[TB] overflow divider 100");
    divider = 32'd100;
    for (int i = 0; i < 6; i++) begin
      txData = 8'h11 + 8'(i);
      txValid = 1'b1;
      @(negedge clk);
    end
    txValid = 1'b0;
    checkOutput("ovfStatus", txStatus, 32'h4D);
    expectFrame(8'h11, 100, 1'b0, 1'b0, 1'b0, 4, 0);
    expectFrame(8'h12, 100, 1'b0, 1'b0, 1'b0, 0, 1);
    expectFrame(8'h13, 100, 1'b0, 1'b0, 1'b0, 0, 1);
    expectFrame(8'h14, 100, 1'b0, 1'b0, 1'b0, 0, 1);
    expectFrame(8'h15, 100, 1'b0, 1'b0, 1'b0, 0, 1);
    for (int i = 0; i < 200; i++) begin
      checkOutput("noSixthFrame", 32'({txLine, txStatus[0]}), 32'h2);
      @(negedge clk);
    end
    checkOutput("ovfIdleStatus", txStatus, 32'h0A);

    // Interrupt sources and overflow clear
    checkOutput("irqMasked", 32'(txIrq), 32'd0);
    irqMask = 2'b10;
    @(negedge clk);
    checkOutput("irqOvf", 32'(txIrq), 32'd1);
    irqMask = 2'b01;
    @(negedge clk);
    checkOutput("irqEmpty", 32'(txIrq), 32'd1);
    irqMask = 2'b00;
    @(negedge clk);
    checkOutput("irqOff", 32'(txIrq), 32'd0);
    irqMask = 2'b10;
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("ovfCleared", txStatus, 32'h2);
    @(negedge clk);
    checkOutput("irqOvfCleared", 32'(txIrq), 32'd0);
    irqMask = 2'b00;

    // Divider 0 holds a queued byte until a valid divider appears
    $display("[TB] divider 0 blocks start");
    divider = 32'd0;
    applyStimulus(8'h3C);
    for (int i = 0; i < 10; i++) begin
      checkOutput("div0Idle", 32'({txLine, txStatus[0]}), 32'h2);
      @(negedge clk);
    end
    checkOutput("div0Status", txStatus, 32'h10);
    divider = 32'd8;
    expectFrame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 0, 1);

    // Fill with transmitter disabled, then write while the head is popped
    $display("[TB] full FIFO with simultaneous pop");
    divider = 32'd2;
    txEn = 1'b0;
    applyStimulus(8'hA1);
    applyStimulus(8'hA2);
    applyStimulus(8'hA3);
    applyStimulus(8'hA4);
    checkOutput("fullStatus", txStatus, 32'h44);
    txEn = 1'b1;
    applyStimulus(8'hA5);
    checkOutput("fullPopStatus", txStatus, 32'h45);
    // Settings changed mid-frame must not disturb the frame in flight
    txEn = 1'b0;
    divider = 32'd0;
    parityEn = 1'b1;
    stop2 = 1'b1;
    expectFrame(8'hA1, 2, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("disabledIdle", 32'({txLine, txStatus[0]}), 32'h2);
      @(negedge clk);
    end
    checkOutput("disabledStatus", txStatus, 32'h44);
    parityEn = 1'b0;
    stop2 = 1'b0;

    // Reset in the middle of the data bits of 0xA2
    $display("[TB] reset during DATA");
    divider = 32'd4;
    txEn = 1'b1;
    @(negedge clk);
    checkOutput("a2Start", 32'({txLine, txStatus[0]}), 32'h1);
    repeat (5) @(negedge clk);
    checkOutput("a2Bit0", 32'({txLine, txStatus[0]}), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRstTx", 32'(txLine), 32'd1);
    checkOutput("midRstStatus", txStatus, 32'h2);
    checkOutput("midRstIrq", 32'(txIrq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      checkOutput("noFrameAfterRst", 32'({txLine, txStatus[0]}), 32'h2);
      @(negedge clk);
    end

    // Overflow set beats a simultaneous clear
    $display("[TB] overflow priority over clear");
    txEn = 1'b0;
    applyStimulus(8'hB1);
    applyStimulus(8'hB2);
    applyStimulus(8'hB3);
    applyStimulus(8'hB4);
    checkOutput("refillStatus", txStatus, 32'h44);
    ovfClr = 1'b1;
    applyStimulus(8'h99);
    ovfClr = 1'b0;
    checkOutput("ovfPriority", txStatus, 32'h4C);
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("ovfClrOnly", txStatus, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries; the value SHALL be a power of two in the range 2..8.
REQ-002 SHALL have port clk, input, 1, system clock; all logic SHALL be clocked on the rising edge of clk.
REQ-003 SHALL have port rst_n, input, 1, reset; reset SHALL be asynchronous and active-low.
REQ-004 SHALL have port divider_i, input, 32, clock cycles per bit period.
REQ-005 SHALL have port tx_en_i, input, 1, transmitter enable.
REQ-006 SHALL have port parity_en_i, input, 1, parity bit enable.
REQ-007 SHALL have port parity_odd_i, input, 1, selects odd parity when 1 and even parity when 0.
REQ-008 SHALL have port stop2_i, input, 1, selects two stop bits when 1 and one stop bit when 0.
REQ-009 SHALL have port tx_d_i, input, 8, byte to transmit.
REQ-010 SHALL have port tx_d_valid_i, input, 1, single-cycle write strobe with no ready signal.
REQ-011 SHALL have port ovf_clr_i, input, 1, pulse that clears the overflow flag.
REQ-012 SHALL have port txirqmask_i, input, 2, interrupt mask.
REQ-013 SHALL have port tx_o, output, 1, serial line, idle high.
REQ-014 SHALL have port tx_status_o, output, 32, status word.
REQ-015 SHALL have port tx_irq_o, output, 1, level interrupt.

Function
REQ-016 SHALL buffer writes in a FIFO_DEPTH-entry FIFO; a write occurs when tx_d_valid_i=1 and the FIFO is not full.
REQ-017 SHALL drop a write made while the FIFO is full with no pop in the same cycle, and SHALL set the sticky overflow flag.
REQ-018 SHALL accept a write to a full FIFO when a pop happens in the same cycle; occupancy is then unchanged and overflow is not set.
REQ-019 SHALL clear overflow on ovf_clr_i=1; a simultaneous overflow event SHALL take priority, leaving overflow=1.
REQ-020 SHALL use the states IDLE, START, DATA, PARITY, STOP.
REQ-021 In IDLE: when the FIFO is non-empty, tx_en_i=1 and divider_i!=0, the FIFO SHALL pop that cycle and the state SHALL go to START.
REQ-022 On that pop: the byte, divider_i, parity_en_i, parity_odd_i and stop2_i SHALL be latched for the frame; input changes mid-frame SHALL NOT affect it.
REQ-023 SHALL drive tx_o from a register: 0 in START, data bits LSB-first in DATA, parity in PARITY, 1 in STOP and IDLE.
REQ-024 Each bit SHALL last exactly the latched divider clock cycles, timed by a counter loaded with divider-1 that counts down to 0.
REQ-025 DATA SHALL last 8 bit periods, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-026 The parity bit SHALL be the XOR of the 8 data bits, inverted when odd parity is selected.
REQ-027 STOP SHALL last 1 or 2 bit periods, then go to IDLE.
REQ-028 A frame SHALL occupy divider*(10+p+s) cycles, where p is 1 with parity enabled and s is 1 with two stop bits.
REQ-029 Latency: with the FIFO empty and idle, strobe in cycle N SHALL make tx_o fall at the clock edge ending cycle N+1.
REQ-030 Back-to-back frames: if the FIFO is non-empty at STOP end, the state SHALL spend exactly 1 cycle in IDLE, then start the next frame.
REQ-031 Deasserting tx_en_i or setting divider_i=0 SHALL only block new frames; a frame in progress SHALL complete.
REQ-032 tx_status_o SHALL be: [0] busy (state!=IDLE), [1] FIFO empty, [2] FIFO full, [3] overflow, [7:4] FIFO count, [31:8] zero.
REQ-033 tx_irq_o SHALL equal (txirqmask_i[0] & FIFO empty & !busy) | (txirqmask_i[1] & overflow), registered.

Reset
REQ-034 On reset assertion, mid-frame or otherwise: tx_o=1, state=IDLE, FIFO empty, overflow=0, tx_irq_o=0, counters=0.
REQ-035 tx_status_o SHALL equal 0x00000002 during reset; any partial frame SHALL be abandoned with no completion.

Verification
REQ-036 SHALL cover: divider=4, 8N1, write 0x55 -> tx_o: 0 for 4 cycles; bits 1,0,1,0,1,0,1,0 at 4 cycles each; 1; frame 40 cycles.
REQ-037 SHALL cover: divider=2, even parity, write 0x07 -> parity bit 1; same with odd parity -> 0; frames 22 cycles.
REQ-038 SHALL cover: divider=3, two stop bits, write 0xA0 then 0x0F back-to-back -> stop high 6 cycles plus 1 idle; second start follows.
REQ-039 SHALL cover: divider=100, 6 writes in consecutive cycles -> first popped, next 4 buffered, sixth dropped; overflow=1; 5 frames sent.
REQ-040 SHALL cover: divider=0 with a byte queued -> tx_o stays 1, count=1; then divider=8 -> frame starts on the next idle cycle.
REQ-041 SHALL cover: rst_n low during DATA -> tx_o=1 immediately, status 0x00000002, no further frame after release.
